// File: rtl/view_pkg.sv
// Shared types and constants for the camera-basis generator.
//   ANGLE_W   : signed angle input width (whole degrees)
//   OUT_W     : signed output component width
//   FRAC      : fractional bits of outputs (Q16.16)
//   TRIG_FRAC : fractional bits of sine LUT entries
package view_pkg;

  localparam int unsigned ANGLE_W   = 16;
  localparam int unsigned OUT_W     = 32;
  localparam int unsigned FRAC      = 16;
  localparam int unsigned TRIG_FRAC = 16;
  localparam int unsigned ONE_Q16   = 65536;

  // Normalised angle 0..359 and signed Q1.16 trig value (+/-65536 needs 18 bits)
  localparam int unsigned DEG_W  = 9;
  localparam int unsigned TRIG_W = 18;
  localparam int unsigned PROD_W = 2 * TRIG_W;

  localparam logic signed [PROD_W-1:0] Q_RND = PROD_W'(32768);

  typedef logic signed [TRIG_W-1:0] trig_t;

  typedef struct packed {
    logic signed [OUT_W-1:0] x;
    logic signed [OUT_W-1:0] y;
    logic signed [OUT_W-1:0] z;
  } vec3_t;

  typedef enum logic [2:0] {
    ST_CAPTURE,
    ST_LOOKUP,
    ST_MUL1,
    ST_MUL2,
    ST_PUBLISH
  } state_t;

  // Q16 x Q16 at full width, arithmetic shift back with round-half-up
  function automatic trig_t q16_mul(input trig_t a, input trig_t b);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    p = p + Q_RND;
    return TRIG_W'(p >>> TRIG_FRAC);
  endfunction

  // Reduce a signed degree count into 0..359 (remainder takes dividend sign)
  function automatic logic [DEG_W-1:0] wrap_deg(input logic signed [ANGLE_W-1:0] a);
    logic signed [ANGLE_W-1:0] r;
    r = a % ANGLE_W'(360);
    if (r[ANGLE_W-1]) r = r + ANGLE_W'(360);
    return DEG_W'(r);
  endfunction

  function automatic logic signed [OUT_W-1:0] to_out(input trig_t v);
    return OUT_W'(v);
  endfunction

endpackage

// File: rtl/trig_lut.sv
// Quarter-wave sine table with quadrant folding; cosine is sine shifted by 90.
//   angle_i : degrees 0..359
//   sin_c_o : sin(angle) Q1.16 signed (combinational)
//   cos_c_o : cos(angle) Q1.16 signed (combinational)
module trig_lut
  import view_pkg::*;
(
  input  logic [DEG_W-1:0] angle_i,
  output trig_t            sin_c_o,
  output trig_t            cos_c_o
);

  // round(sin(d) * 65536) for d = 0..90
  function automatic logic [16:0] quarter_sin(input logic [6:0] d);
    logic [16:0] v;
    case (d)
      7'd0:  v = 17'd0;     7'd1:  v = 17'd1144;  7'd2:  v = 17'd2287;
      7'd3:  v = 17'd3430;  7'd4:  v = 17'd4572;  7'd5:  v = 17'd5712;
      7'd6:  v = 17'd6850;  7'd7:  v = 17'd7987;  7'd8:  v = 17'd9121;
      7'd9:  v = 17'd10252; 7'd10: v = 17'd11380; 7'd11: v = 17'd12505;
      7'd12: v = 17'd13626; 7'd13: v = 17'd14742; 7'd14: v = 17'd15855;
      7'd15: v = 17'd16962; 7'd16: v = 17'd18064; 7'd17: v = 17'd19161;
      7'd18: v = 17'd20252; 7'd19: v = 17'd21336; 7'd20: v = 17'd22415;
      7'd21: v = 17'd23486; 7'd22: v = 17'd24550; 7'd23: v = 17'd25607;
      7'd24: v = 17'd26656; 7'd25: v = 17'd27697; 7'd26: v = 17'd28729;
      7'd27: v = 17'd29753; 7'd28: v = 17'd30767; 7'd29: v = 17'd31772;
      7'd30: v = 17'd32768; 7'd31: v = 17'd33754; 7'd32: v = 17'd34729;
      7'd33: v = 17'd35693; 7'd34: v = 17'd36647; 7'd35: v = 17'd37590;
      7'd36: v = 17'd38521; 7'd37: v = 17'd39441; 7'd38: v = 17'd40348;
      7'd39: v = 17'd41243; 7'd40: v = 17'd42126; 7'd41: v = 17'd42995;
      7'd42: v = 17'd43852; 7'd43: v = 17'd44695; 7'd44: v = 17'd45525;
      7'd45: v = 17'd46341; 7'd46: v = 17'd47143; 7'd47: v = 17'd47930;
      7'd48: v = 17'd48703; 7'd49: v = 17'd49461; 7'd50: v = 17'd50203;
      7'd51: v = 17'd50931; 7'd52: v = 17'd51643; 7'd53: v = 17'd52339;
      7'd54: v = 17'd53020; 7'd55: v = 17'd53684; 7'd56: v = 17'd54332;
      7'd57: v = 17'd54963; 7'd58: v = 17'd55578; 7'd59: v = 17'd56175;
      7'd60: v = 17'd56756; 7'd61: v = 17'd57319; 7'd62: v = 17'd57865;
      7'd63: v = 17'd58393; 7'd64: v = 17'd58903; 7'd65: v = 17'd59396;
      7'd66: v = 17'd59870; 7'd67: v = 17'd60326; 7'd68: v = 17'd60764;
      7'd69: v = 17'd61183; 7'd70: v = 17'd61584; 7'd71: v = 17'd61965;
      7'd72: v = 17'd62328; 7'd73: v = 17'd62672; 7'd74: v = 17'd62997;
      7'd75: v = 17'd63303; 7'd76: v = 17'd63589; 7'd77: v = 17'd63856;
      7'd78: v = 17'd64104; 7'd79: v = 17'd64332; 7'd80: v = 17'd64540;
      7'd81: v = 17'd64729; 7'd82: v = 17'd64898; 7'd83: v = 17'd65047;
      7'd84: v = 17'd65177; 7'd85: v = 17'd65287; 7'd86: v = 17'd65376;
      7'd87: v = 17'd65446; 7'd88: v = 17'd65496; 7'd89: v = 17'd65526;
      default: v = 17'd65536;
    endcase
    return v;
  endfunction

  // Fold 0..359 onto the first quadrant; sign is negative in the lower half-circle
  function automatic trig_t sin_deg(input logic [DEG_W-1:0] a);
    logic [16:0] m;
    logic        neg;
    m   = '0;
    neg = 1'b0;
    if (a <= 9'd90) begin
      m = quarter_sin(7'(a));
    end else if (a <= 9'd180) begin
      m = quarter_sin(7'(9'd180 - a));
    end else if (a <= 9'd270) begin
      m   = quarter_sin(7'(a - 9'd180));
      neg = 1'b1;
    end else begin
      m   = quarter_sin(7'(9'd360 - a));
      neg = 1'b1;
    end
    return neg ? -$signed({1'b0, m}) : $signed({1'b0, m});
  endfunction

  logic [DEG_W-1:0] cos_angle;

  always_comb begin
    cos_angle = (angle_i >= 9'd270) ? (angle_i - 9'd270) : (angle_i + 9'd90);
    sin_c_o   = sin_deg(angle_i);
    cos_c_o   = sin_deg(cos_angle);
  end

endmodule

// File: rtl/view_output_simple_rtl.sv
// Euler angles (pitch, roll, yaw in degrees) to camera basis vectors, Q16.16.
// R = Ry(yaw) * Rx(pitch) * Rz(roll); right/up/forward are R's columns.
//   clk_100mhz, rst_in (async, active-low)
//   pitch, roll, yaw : signed degree inputs, sampled once per 10-cycle period
//   {x,y,z}_{forward,up,right} : signed Q16.16 outputs, updated at PUBLISH
//   valid_out : set on first publish, held until reset
module view_output_simple_rtl
  import view_pkg::*;
(
  input  logic                      clk_100mhz,
  input  logic                      rst_in,
  input  logic signed [ANGLE_W-1:0] pitch,
  input  logic signed [ANGLE_W-1:0] roll,
  input  logic signed [ANGLE_W-1:0] yaw,
  output logic signed [OUT_W-1:0]   x_forward,
  output logic signed [OUT_W-1:0]   y_forward,
  output logic signed [OUT_W-1:0]   z_forward,
  output logic signed [OUT_W-1:0]   x_up,
  output logic signed [OUT_W-1:0]   y_up,
  output logic signed [OUT_W-1:0]   z_up,
  output logic signed [OUT_W-1:0]   x_right,
  output logic signed [OUT_W-1:0]   y_right,
  output logic signed [OUT_W-1:0]   z_right,
  output logic                      valid_out
);

  localparam logic [2:0] LAST_LOOKUP = 3'd5;

  state_t           state_q;
  logic [2:0]       lk_idx_q;
  logic [DEG_W-1:0] ap_q, ar_q, ay_q;
  trig_t            sp_q, cp_q, sr_q, cr_q, sy_q, cy_q;
  trig_t            crcy_q, srsp_q, srcp_q, crsy_q, srcy_q;
  trig_t            crsp_q, crcp_q, srsy_q, cpsy_q, cpcy_q;
  vec3_t            fwd_q, up_q, right_q;

  logic [DEG_W-1:0] lut_angle_c;
  trig_t            lut_sin_c, lut_cos_c, lut_val_c;

  trig_lut u_trig_lut (
    .angle_i (lut_angle_c),
    .sin_c_o (lut_sin_c),
    .cos_c_o (lut_cos_c)
  );

  // Lookup order: sp, cp, sr, cr, sy, cy -- odd slots take the cosine
  always_comb begin
    lut_angle_c = ap_q;
    case (lk_idx_q[2:1])
      2'd0:    lut_angle_c = ap_q;
      2'd1:    lut_angle_c = ar_q;
      default: lut_angle_c = ay_q;
    endcase
    lut_val_c = lk_idx_q[0] ? lut_cos_c : lut_sin_c;
  end

  // Sequencer, trig/product pipeline and registered outputs
  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_CAPTURE;
      lk_idx_q  <= '0;
      ap_q      <= '0;
      ar_q      <= '0;
      ay_q      <= '0;
      sp_q      <= '0;
      cp_q      <= '0;
      sr_q      <= '0;
      cr_q      <= '0;
      sy_q      <= '0;
      cy_q      <= '0;
      crcy_q    <= '0;
      srsp_q    <= '0;
      srcp_q    <= '0;
      crsy_q    <= '0;
      srcy_q    <= '0;
      crsp_q    <= '0;
      crcp_q    <= '0;
      srsy_q    <= '0;
      cpsy_q    <= '0;
      cpcy_q    <= '0;
      fwd_q     <= '0;
      up_q      <= '0;
      right_q   <= '0;
      x_forward <= '0;
      y_forward <= '0;
      z_forward <= '0;
      x_up      <= '0;
      y_up      <= '0;
      z_up      <= '0;
      x_right   <= '0;
      y_right   <= '0;
      z_right   <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          ap_q     <= wrap_deg(pitch);
          ar_q     <= wrap_deg(roll);
          ay_q     <= wrap_deg(yaw);
          lk_idx_q <= '0;
          state_q  <= ST_LOOKUP;
        end
        ST_LOOKUP: begin
          case (lk_idx_q)
            3'd0:    sp_q <= lut_val_c;
            3'd1:    cp_q <= lut_val_c;
            3'd2:    sr_q <= lut_val_c;
            3'd3:    cr_q <= lut_val_c;
            3'd4:    sy_q <= lut_val_c;
            default: cy_q <= lut_val_c;
          endcase
          lk_idx_q <= lk_idx_q + 3'd1;
          if (lk_idx_q == LAST_LOOKUP) state_q <= ST_MUL1;
        end
        ST_MUL1: begin
          crcy_q  <= q16_mul(cr_q, cy_q);
          srsp_q  <= q16_mul(sr_q, sp_q);
          srcp_q  <= q16_mul(sr_q, cp_q);
          crsy_q  <= q16_mul(cr_q, sy_q);
          srcy_q  <= q16_mul(sr_q, cy_q);
          crsp_q  <= q16_mul(cr_q, sp_q);
          crcp_q  <= q16_mul(cr_q, cp_q);
          srsy_q  <= q16_mul(sr_q, sy_q);
          cpsy_q  <= q16_mul(cp_q, sy_q);
          cpcy_q  <= q16_mul(cp_q, cy_q);
          state_q <= ST_MUL2;
        end
        ST_MUL2: begin
          // Three-factor terms reuse the rounded two-factor products
          right_q <= '{x: to_out(crcy_q + q16_mul(srsp_q, sy_q)),
                       y: to_out(srcp_q),
                       z: to_out(q16_mul(srsp_q, cy_q) - crsy_q)};
          up_q    <= '{x: to_out(q16_mul(crsp_q, sy_q) - srcy_q),
                       y: to_out(crcp_q),
                       z: to_out(srsy_q + q16_mul(crsp_q, cy_q))};
          fwd_q   <= '{x: to_out(cpsy_q),
                       y: to_out(-sp_q),
                       z: to_out(cpcy_q)};
          state_q <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          x_forward <= fwd_q.x;
          y_forward <= fwd_q.y;
          z_forward <= fwd_q.z;
          x_up      <= up_q.x;
          y_up      <= up_q.y;
          z_up      <= up_q.z;
          x_right   <= right_q.x;
          y_right   <= right_q.y;
          z_right   <= right_q.z;
          valid_out <= 1'b1;
          state_q   <= ST_CAPTURE;
        end
        default: state_q <= ST_CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_view_output_simple_rtl.sv
// Bench for view_output_simple_rtl: directed and random angles against a
// floating-point rotation-matrix model, plus reset and update-timing checks.
module tb_view_output_simple_rtl;

  localparam real PI = 3.14159265358979323846;

  logic               clk_100mhz;
  logic               rst_in;
  logic signed [15:0] pitch, roll, yaw;
  logic signed [31:0] x_forward, y_forward, z_forward;
  logic signed [31:0] x_up, y_up, z_up;
  logic signed [31:0] x_right, y_right, z_right;
  logic               valid_out;

  int     total;
  int     bad;
  longint obs[9];
  longint exp_v[9];
  longint prev[9];

  view_output_simple_rtl dut (
    .clk_100mhz (clk_100mhz),
    .rst_in     (rst_in),
    .pitch      (pitch),
    .roll       (roll),
    .yaw        (yaw),
    .x_forward  (x_forward),
    .y_forward  (y_forward),
    .z_forward  (z_forward),
    .x_up       (x_up),
    .y_up       (y_up),
    .z_up       (z_up),
    .x_right    (x_right),
    .y_right    (y_right),
    .z_right    (z_right),
    .valid_out  (valid_out)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string tag, input longint got, input longint want, input longint tol);
    total++;
    if (got > want + tol || got < want - tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, got, want, tol);
    end
  endtask

  // Order: forward xyz, up xyz, right xyz
  task automatic snap();
    obs[0] = x_forward; obs[1] = y_forward; obs[2] = z_forward;
    obs[3] = x_up;      obs[4] = y_up;      obs[5] = z_up;
    obs[6] = x_right;   obs[7] = y_right;   obs[8] = z_right;
  endtask

  function automatic longint q16(input real v);
    return longint'($floor(v * 65536.0 + 0.5));
  endfunction

  // Build Ry*Rx*Rz from ideal trig and take its columns
  task automatic model(input int p, input int r, input int y);
    real s[3], c[3];
    real mx[3][3], my[3][3], mz[3][3], t[3][3], m[3][3];
    real ang[3];
    ang[0] = real'(p); ang[1] = real'(r); ang[2] = real'(y);
    for (int i = 0; i < 3; i++) begin
      s[i] = $sin(ang[i] * PI / 180.0);
      c[i] = $cos(ang[i] * PI / 180.0);
    end
    mx = '{'{1.0, 0.0, 0.0}, '{0.0, c[0], -s[0]}, '{0.0, s[0], c[0]}};
    mz = '{'{c[1], -s[1], 0.0}, '{s[1], c[1], 0.0}, '{0.0, 0.0, 1.0}};
    my = '{'{c[2], 0.0, s[2]}, '{0.0, 1.0, 0.0}, '{-s[2], 0.0, c[2]}};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        t[i][j] = 0.0;
        for (int k = 0; k < 3; k++) t[i][j] += mx[i][k] * mz[k][j];
      end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        m[i][j] = 0.0;
        for (int k = 0; k < 3; k++) m[i][j] += my[i][k] * t[k][j];
      end
    for (int i = 0; i < 3; i++) begin
      exp_v[i]     = q16(m[i][2]);
      exp_v[3 + i] = q16(m[i][1]);
      exp_v[6 + i] = q16(m[i][0]);
    end
  endtask

  task automatic check_basis(input string tag, input int p, input int r, input int y, input int tol);
    model(p, r, y);
    snap();
    for (int i = 0; i < 9; i++) chk($sformatf("%s[%0d]", tag, i), obs[i], exp_v[i], longint'(tol));
  endtask

  task automatic check_zero(input string tag);
    snap();
    for (int i = 0; i < 9; i++) chk($sformatf("%s[%0d]", tag, i), obs[i], 0, 0);
    chk({tag, "_valid"}, longint'(valid_out), 0, 0);
  endtask

  task automatic set_angles(input int p, input int r, input int y);
    pitch = 16'(p);
    roll  = 16'(r);
    yaw   = 16'(y);
  endtask

  // Two full periods guarantee a publish computed from the current angles
  task automatic settle();
    repeat (21) @(posedge clk_100mhz);
    #1;
  endtask

  // Called just after reset release; bounded wait for the first publish
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!valid_out && n < 14) begin
      @(posedge clk_100mhz);
      #1;
      n++;
    end
    chk({tag, "_valid"}, longint'(valid_out), 1, 0);
    chk({tag, "_lat_le10"}, longint'(n <= 10), 1, 0);
  endtask

  initial begin
    int p, r, y, changes;
    total = 0;
    bad   = 0;
    set_angles(0, 0, 0);
    rst_in = 1'b1;
    #2 rst_in = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    #1;
    check_zero("reset");

    @(negedge clk_100mhz) rst_in = 1'b1;
    wait_valid("boot");
    settle();
    check_basis("zero", 0, 0, 0, 1);

    set_angles(20, 0, 20);
    #1000;
    @(posedge clk_100mhz);
    #1;
    check_basis("p20y20", 20, 0, 20, 4);

    set_angles(0, 0, 90);
    settle();
    check_basis("yaw90", 0, 0, 90, 4);

    set_angles(0, -90, 0);
    settle();
    check_basis("rollm90", 0, -90, 0, 4);

    set_angles(0, 270, 0);
    settle();
    check_basis("roll270", 0, 270, 0, 4);

    set_angles(-20, 360, 720);
    settle();
    check_basis("wrap", -20, 360, 720, 4);

    for (int k = 0; k < 16; k++) begin
      p = int'($signed(16'($urandom)));
      r = int'($signed(16'($urandom)));
      y = int'($signed(16'($urandom)));
      set_angles(p, r, y);
      settle();
      check_basis($sformatf("rnd%0d", k), p, r, y, 4);
    end

    // Mid-period angle change: outputs must step once, straight to the new basis
    set_angles(10, 20, 30);
    settle();
    check_basis("pre_chg", 10, 20, 30, 4);
    repeat ($urandom_range(0, 9)) @(posedge clk_100mhz);
    #1;
    snap();
    prev = obs;
    set_angles(-45, 60, 135);
    changes = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk_100mhz);
      #1;
      snap();
      if (obs != prev) changes++;
      prev = obs;
    end
    chk("single_update", longint'(changes), 1, 0);
    check_basis("post_chg", -45, 60, 135, 4);

    // Reset in the middle of LOOKUP while new angles are pending
    set_angles(35, -50, 200);
    @(negedge clk_100mhz) rst_in = 1'b0;
    repeat (2) @(posedge clk_100mhz);
    @(negedge clk_100mhz) rst_in = 1'b1;
    wait_valid("phase");
    check_basis("phase_f", 35, -50, 200, 4);
    repeat (2) @(posedge clk_100mhz);
    #2;
    set_angles(-100, 15, -75);
    repeat (2) @(posedge clk_100mhz);
    #1;
    check_basis("hold_f", 35, -50, 200, 4);
    #1 rst_in = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (2) @(posedge clk_100mhz);
    @(negedge clk_100mhz) rst_in = 1'b1;
    wait_valid("restart");
    check_basis("restart_e", -100, 15, -75, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/view_output_simple_rtl.md
Name: view_output_simple_rtl

Overview:
- Converts camera Euler angles (pitch, roll, yaw; integer degrees) into an orthonormal camera basis: forward, up and right vectors.
- Each vector component is a signed Q16.16 fixed-point value.
- Sits between the orientation source (IMU/controls) and the ray generator, which consumes the basis vectors.
- Free-running: continuously re-samples the angles and refreshes the outputs.

Parameters:
- ANGLE_W, 16: width of signed angle inputs, in whole degrees.
- OUT_W, 32: width of each signed output component.
- FRAC, 16: fractional bits of outputs (Q16.16, so 1.0 = 65536).
- TRIG_FRAC, 16: fractional bits of the internal sine LUT entries.

Ports:
- clk_100mhz  in  1  system clock, 100 MHz.
- rst_in  in  1  reset; asynchronous assert, active-low.
- pitch  in  ANGLE_W signed  rotation about X, degrees.
- roll  in  ANGLE_W signed  rotation about Z, degrees.
- yaw  in  ANGLE_W signed  rotation about Y, degrees.
- x_forward, y_forward, z_forward  out  OUT_W signed  forward vector.
- x_up, y_up, z_up  out  OUT_W signed  up vector.
- x_right, y_right, z_right  out  OUT_W signed  right vector.
- valid_out  out  1  high once the first basis has been published; stays high until reset.

Behaviour:
- Reset (rst_in low, asynchronous): all nine vector outputs are 0, valid_out is 0, FSM goes to CAPTURE, and all internal registers clear. Deasserting reset mid-computation therefore restarts the computation cleanly.
- Angle normalisation: each captured angle is reduced modulo 360 into the range 0..359. Negative inputs wrap, so -20 becomes 340.
- Trig source: one shared quarter-wave sine LUT, 91 entries for 0..90°, Q1.16 unsigned, rounded to nearest.
  - Full-circle sine is obtained by quadrant folding.
  - cos(a) = sin(a+90).
  - sin(90) = 65536 exactly.
- FSM: CAPTURE (1 cycle) -> LOOKUP (6 cycles) -> MUL1 (1) -> MUL2 (1) -> PUBLISH (1) -> CAPTURE.
  - CAPTURE: latch pitch, roll and yaw.
  - LOOKUP: fetch one of sp, cp, sr, cr, sy, cy per cycle.
  - MUL1: form two-term products.
  - MUL2: form three-term products and sums.
  - PUBLISH: update all nine outputs simultaneously and set valid_out.
- Timing: the update period is 10 cycles. Outputs reflect angles sampled at most 10 cycles before publication, and they hold their value between publishes. Angle changes during a period do not affect that period's result.
- Rotation convention: R = Ry(yaw)·Rx(pitch)·Rz(roll).
  - right = R·(1,0,0) = (cr·cy + sr·sp·sy, sr·cp, -cr·sy + sr·sp·cy)
  - up = R·(0,1,0) = (-sr·cy + cr·sp·sy, cr·cp, sr·sy + cr·sp·cy)
  - forward = R·(0,0,1) = (cp·sy, -sp, cp·cy)
- Arithmetic:
  - Each Q16 × Q16 product is kept at full width (at least 34 bits signed), then arithmetically shifted right by TRIG_FRAC with round-half-up.
  - Three-factor terms are shifted after each multiply.
  - Results are sign-extended to OUT_W.
  - Magnitude never exceeds 65536 + 2, so no saturation is needed.
  - Required accuracy: each component within ±4 LSB of ideal × 65536.
- Zero angles give forward=(0,0,65536), up=(0,65536,0), right=(65536,0,0).

Decomposition:
- Shared package view_pkg holds:
  - the OUT_W/FRAC constants;
  - a vec3_t struct of three signed OUT_W fields;
  - the ONE_Q16 = 65536 constant;
  - the state enum.
- One sub-module, trig_lut: combinational/registered sine lookup with quadrant folding.
  - Input: angle 0..359.
  - Outputs: sin and cos, Q1.16 signed.

Test Plan:
- Reset held low for 3 cycles -> all nine outputs 0 and valid_out 0. Release reset -> valid_out rises within 10 cycles.
- pitch=0, roll=0, yaw=0 -> forward (0,0,65536), up (0,65536,0), right (65536,0,0), each ±1.
- pitch=20, roll=0, yaw=20, sampled after 1000 ns -> forward ≈ (21063,-22415,57870), up ≈ (7666,61584,21063), right ≈ (61584,0,-22415), each ±4.
- yaw=90 only -> forward ≈ (65536,0,0), right ≈ (0,0,-65536), up (0,65536,0).
- roll=-90 versus roll=270 -> identical outputs; right ≈ (0,-65536,0), up ≈ (65536,0,0).
- Change angles mid-period, then assert reset mid-LOOKUP:
  - outputs update only at PUBLISH;
  - reset zeroes outputs immediately (asynchronous).
  - After release, the first publish uses the new angles.
